// File: rtl/seg7_scan_encoder_pkg.sv
// seg7_scan_encoder_pkg: segment pattern constants and FSM state type shared by the scan encoder.
package seg7_scan_encoder_pkg;
    typedef logic [0:6] seg_t;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    typedef enum logic [1:0] {IDLE, FILTER, COMMIT, HOLD} state_t;
endpackage

// File: rtl/seg7_scan_encoder_lookup.sv
// seg7_pattern_lookup: maps an active-low a..g pattern back to its hex value.
module seg7_pattern_lookup
    import seg7_scan_encoder_pkg::*;
(
    input  logic [0:6] Seg,
    output logic [3:0] Hex,
    output logic       Hit,
    output logic       IsBlank
);
    always_comb begin
        Hex = 4'h0;
        Hit = 1'b1;
        IsBlank = 1'b0;
        case (Seg)
            SEG_HEX[0]:  Hex = 4'h0;
            SEG_HEX[1]:  Hex = 4'h1;
            SEG_HEX[2]:  Hex = 4'h2;
            SEG_HEX[3]:  Hex = 4'h3;
            SEG_HEX[4]:  Hex = 4'h4;
            SEG_HEX[5]:  Hex = 4'h5;
            SEG_HEX[6]:  Hex = 4'h6;
            SEG_HEX[7]:  Hex = 4'h7;
            SEG_HEX[8]:  Hex = 4'h8;
            SEG_HEX[9]:  Hex = 4'h9;
            SEG_HEX[10]: Hex = 4'hA;
            SEG_HEX[11]: Hex = 4'hB;
            SEG_HEX[12]: Hex = 4'hC;
            SEG_HEX[13]: Hex = 4'hD;
            SEG_HEX[14]: Hex = 4'hE;
            SEG_HEX[15]: Hex = 4'hF;
            SEG_BLANK: begin
                Hit = 1'b0;
                IsBlank = 1'b1;
            end
            default:     Hit = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg7_scan_encoder.sv
// seg7_scan_encoder: debounces a strobed 7-segment bus, encodes each digit to hex
// and assembles a multi-digit word with per-frame completion tracking.
module seg7_scan_encoder
    import seg7_scan_encoder_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int STABLE_CYCLES = 3,
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1,
    localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic [0:6]        Seg,
    input  logic              Strobe,
    input  logic [IW-1:0]     DigIdx,
    output logic [3:0]        Hex,
    output logic [IW-1:0]     HexIdx,
    output logic              Valid,
    output logic              Blank,
    output logic              Err,
    output logic [4*NDIG-1:0] Word,
    output logic              FrameDone
);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:6] seg_r_q, seg_r_d;
    logic [IW-1:0] idx_r_q, idx_r_d, hex_idx_q, hex_idx_d;
    logic [3:0] hex_q, hex_d, lk_hex;
    logic valid_q, valid_d, blank_q, blank_d, err_q, err_d, frame_q, frame_d;
    logic [4*NDIG-1:0] word_q, word_d;
    logic [NDIG-1:0] mask_q, mask_d, mask_set;
    logic lk_hit, lk_blank;

    seg7_pattern_lookup u_lookup (
        .Seg(seg_r_q),
        .Hex(lk_hex),
        .Hit(lk_hit),
        .IsBlank(lk_blank)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        seg_r_d = seg_r_q;
        idx_r_d = idx_r_q;
        hex_d = hex_q;
        hex_idx_d = hex_idx_q;
        valid_d = 1'b0;
        blank_d = 1'b0;
        err_d = 1'b0;
        frame_d = 1'b0;
        word_d = word_q;
        mask_d = mask_q;
        mask_set = mask_q;
        case (state_q)
            IDLE: if (Strobe) begin
                seg_r_d = Seg;
                idx_r_d = DigIdx;
                cnt_d = CW'(1);
                state_d = (STABLE_CYCLES == 1) ? COMMIT : FILTER;
            end
            FILTER: begin
                if (!Strobe) begin
                    state_d = IDLE;
                end else if (Seg != seg_r_q || DigIdx != idx_r_q) begin
                    seg_r_d = Seg;
                    idx_r_d = DigIdx;
                    cnt_d = CW'(1);
                end else if (cnt_q == CW'(STABLE_CYCLES)) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COMMIT: begin
                state_d = HOLD;
                hex_idx_d = idx_r_q;
                if (int'(idx_r_q) >= NDIG || !(lk_hit || lk_blank)) begin
                    err_d = 1'b1;
                end else begin
                    blank_d = lk_blank;
                    valid_d = !lk_blank;
                    hex_d = lk_blank ? hex_q : lk_hex;
                    for (int k = 0; k < NDIG; k++) begin
                        if (idx_r_q == IW'(k)) begin
                            word_d[4*k +: 4] = lk_blank ? 4'h0 : lk_hex;
                            mask_set[k] = 1'b1;
                        end
                    end
                    // A completed frame is reported once and tracking starts afresh.
                    frame_d = &mask_set;
                    mask_d = (&mask_set) ? '0 : mask_set;
                end
            end
            HOLD: if (!Strobe) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q <= '0;
            seg_r_q <= '0;
            idx_r_q <= '0;
            hex_q <= '0;
            hex_idx_q <= '0;
            valid_q <= 1'b0;
            blank_q <= 1'b0;
            err_q <= 1'b0;
            frame_q <= 1'b0;
            word_q <= '0;
            mask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            seg_r_q <= seg_r_d;
            idx_r_q <= idx_r_d;
            hex_q <= hex_d;
            hex_idx_q <= hex_idx_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            err_q <= err_d;
            frame_q <= frame_d;
            word_q <= word_d;
            mask_q <= mask_d;
        end
    end

    assign Hex = hex_q;
    assign HexIdx = hex_idx_q;
    assign Valid = valid_q;
    assign Blank = blank_q;
    assign Err = err_q;
    assign Word = word_q;
    assign FrameDone = frame_q;
endmodule

// File: tb/tb_seg7_scan_encoder.sv
// tb_seg7_scan_encoder: randomized and directed stimulus with a queue-based scoreboard
// against a digit/mask reference model.
module tb_seg7_scan_encoder;
    logic Clk = 1'b0;
    logic Resetn, Strobe;
    logic [0:6] Seg;
    logic [1:0] DigIdx, HexIdx;
    logic [3:0] Hex;
    logic Valid, Blank, Err, FrameDone;
    logic [15:0] Word;

    seg7_scan_encoder #(.NDIG(4), .STABLE_CYCLES(3)) dut (
        .Clk(Clk), .Resetn(Resetn), .Seg(Seg), .Strobe(Strobe), .DigIdx(DigIdx),
        .Hex(Hex), .HexIdx(HexIdx), .Valid(Valid), .Blank(Blank), .Err(Err),
        .Word(Word), .FrameDone(FrameDone)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int kind;
        logic [3:0] hex;
        logic [1:0] idx;
        logic [15:0] word;
        logic frame;
        int cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0, cyc = 0;
    bit mon_en = 0;
    logic [6:0] tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [3:0] m_word [4];
    bit m_mask [4];
    logic [3:0] m_hex;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_word[i] = 4'h0;
            m_mask[i] = 1'b0;
        end
        m_hex = 4'h0;
    endfunction

    // kind: 0 recognised, 1 blank, 2 unknown
    function automatic void classify(input logic [6:0] s, output int kind, output logic [3:0] v);
        kind = (s == 7'h7f) ? 1 : 2;
        v = 4'h0;
        for (int i = 0; i < 16; i++)
            if (s == tbl[i]) begin
                kind = 0;
                v = 4'(i);
            end
    endfunction

    function automatic void push_commit(input logic [6:0] s, input logic [1:0] idx, input int at);
        exp_t e;
        logic [3:0] v;
        int kind;
        classify(s, kind, v);
        e.kind = kind;
        e.idx = idx;
        e.frame = 1'b0;
        e.cyc = at;
        if (kind != 2) begin
            m_word[idx] = (kind == 1) ? 4'h0 : v;
            m_mask[idx] = 1'b1;
            if (m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3]) begin
                e.frame = 1'b1;
                for (int i = 0; i < 4; i++) m_mask[i] = 1'b0;
            end
            if (kind == 0) m_hex = v;
        end
        e.hex = m_hex;
        e.word = {m_word[3], m_word[2], m_word[1], m_word[0]};
        q.push_back(e);
    endfunction

    // Called just after a falling edge; the next rising edge is the first sample.
    task automatic drive(input logic [6:0] s, input logic [1:0] idx, input int len);
        Seg = s;
        DigIdx = idx;
        Strobe = 1'b1;
        if (len >= 4) push_commit(s, idx, cyc + 5);
        repeat (len) @(negedge Clk);
    endtask

    task automatic gap();
        Strobe = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_hex"}, Hex, 0);
        chk({tag, "_idx"}, HexIdx, 0);
        chk({tag, "_pulses"}, {Valid, Blank, Err, FrameDone}, 0);
        chk({tag, "_word"}, Word, 0);
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            if (FrameDone && !(Valid || Blank)) chk("frame_alone", FrameDone, 0);
            if (Valid || Blank || Err) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {Valid, Blank, Err}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("kind", {Valid, Blank, Err},
                        e.kind == 0 ? 3'b100 : e.kind == 1 ? 3'b010 : 3'b001);
                    chk("hex", Hex, e.hex);
                    chk("hexidx", HexIdx, e.idx);
                    chk("word", Word, e.word);
                    chk("framedone", FrameDone, e.frame);
                    chk("latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        Resetn = 1'b0;
        Strobe = 1'b0;
        Seg = 7'h7f;
        DigIdx = 2'd0;
        model_reset();
        repeat (3) @(negedge Clk);
        Resetn = 1'b1;
        @(negedge Clk);
        check_zero("reset");
        mon_en = 1;
        for (int v = 0; v < 16; v++) begin
            drive(tbl[v], 2'd0, 4);
            gap();
        end
        drive(7'b0000001, 2'd0, 2);
        drive(7'b1001111, 2'd0, 4);
        gap();
        drive(tbl[5], 2'd1, 2);
        gap();
        drive(tbl[10], 2'd3, 4); gap();
        drive(tbl[11], 2'd2, 4); gap();
        drive(tbl[12], 2'd1, 4); gap();
        drive(tbl[13], 2'd0, 4); gap();
        drive(7'b1111110, 2'd1, 4); gap();
        drive(7'b1111111, 2'd2, 5); gap();
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [6:0] s;
            r = int'($urandom_range(0, 99));
            s = (r < 60) ? tbl[$urandom_range(0, 15)] : (r < 75) ? 7'h7f : 7'($urandom);
            drive(s, 2'($urandom), int'($urandom_range(1, 6)));
            gap();
        end
        drive(tbl[7], 2'd1, 2);
        Strobe = 1'b0;
        Resetn = 1'b0;
        @(negedge Clk);
        Resetn = 1'b1;
        model_reset();
        check_zero("rst_filter");
        repeat (6) @(negedge Clk);
        check_zero("post_rst");
        drive(tbl[9], 2'd2, 4);
        gap();
        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 20) begin
            @(negedge Clk);
            wait_cnt++;
        end
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
